// File: rtl/alu_op_sequencer_if.sv
// ---------------------------------------------------------------------------
// alu_op_sequencer_if
//   Bundles every non-clock, non-reset signal of the ALU operand sequencer.
//   The sequencer connects through the 'slave' modport. The driving
//   environment (command source, ALU, debug reader) uses 'master'.
//
//   Command channel : cmd_valid/cmd_ready handshake, plus cmd_opc, cmd_dst,
//                     cmd_srca, cmd_srcb and cmd_cin.
//   Load port       : ld_en, ld_addr, ld_data. Writes one register-file entry.
//   ALU side        : alu_a, alu_b, alu_c, alu_opc go out to the ALU.
//                     alu_w, alu_zer, alu_neg come back from it.
//   Result side     : done pulse, result, flag_z, flag_n.
//   Debug           : dbg_addr in. dbg_data is a combinational register read.
// ---------------------------------------------------------------------------
interface alu_op_sequencer_if #(
    parameter int NREG = 4
);
    localparam int AW = (NREG > 1) ? $clog2(NREG) : 1;

    logic          cmd_valid;
    logic          cmd_ready;
    logic [2:0]    cmd_opc;
    logic [AW-1:0] cmd_dst;
    logic [AW-1:0] cmd_srca;
    logic [AW-1:0] cmd_srcb;
    logic          cmd_cin;

    logic          ld_en;
    logic [AW-1:0] ld_addr;
    logic [15:0]   ld_data;

    logic [15:0]   alu_a;
    logic [15:0]   alu_b;
    logic          alu_c;
    logic [2:0]    alu_opc;
    logic [15:0]   alu_w;
    logic          alu_zer;
    logic          alu_neg;

    logic          done;
    logic [15:0]   result;
    logic          flag_z;
    logic          flag_n;

    logic [AW-1:0] dbg_addr;
    logic [15:0]   dbg_data;

    modport slave (
        input  cmd_valid, cmd_opc, cmd_dst, cmd_srca, cmd_srcb, cmd_cin,
        input  ld_en, ld_addr, ld_data,
        input  alu_w, alu_zer, alu_neg,
        input  dbg_addr,
        output cmd_ready,
        output alu_a, alu_b, alu_c, alu_opc,
        output done, result, flag_z, flag_n,
        output dbg_data
    );

    modport master (
        output cmd_valid, cmd_opc, cmd_dst, cmd_srca, cmd_srcb, cmd_cin,
        output ld_en, ld_addr, ld_data,
        output alu_w, alu_zer, alu_neg,
        output dbg_addr,
        input  cmd_ready,
        input  alu_a, alu_b, alu_c, alu_opc,
        input  done, result, flag_z, flag_n,
        input  dbg_data
    );
endinterface

// File: rtl/alu_op_sequencer.sv
// ---------------------------------------------------------------------------
// alu_op_sequencer
//   Control and operand stage in front of a combinational 16-bit ALU.
//   It accepts one command per valid/ready handshake and reads the two
//   source registers. It drives the ALU operand ports from registers,
//   captures the ALU's outW/zer/neg, and writes the result back to the
//   destination register and to the flag registers.
//   Only one command is in flight at a time: IDLE -> FETCH -> EXEC -> WB.
//
// Ports
//   clk  : rising-edge clock
//   rst  : asynchronous reset, active high
//   bus  : alu_op_sequencer_if.slave (command, load, ALU, result, debug)
// ---------------------------------------------------------------------------
module alu_op_sequencer #(
    parameter int NREG = 4
) (
    input  logic               clk,
    input  logic               rst,
    alu_op_sequencer_if.slave  bus
);
    localparam int AW = (NREG > 1) ? $clog2(NREG) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_EXEC  = 2'd2;
    localparam logic [1:0] S_WB    = 2'd3;

    logic [1:0]    r_state;

    // Command fields latched at the handshake edge
    logic [2:0]    r_opc;
    logic [AW-1:0] r_dst;
    logic [AW-1:0] r_srca;
    logic [AW-1:0] r_srcb;
    logic          r_cin;

    // Registered ALU drive
    logic [15:0]   r_alu_a;
    logic [15:0]   r_alu_b;
    logic          r_alu_c;
    logic [2:0]    r_alu_opc;

    // Capture and architectural flags
    logic [15:0]   r_result;
    logic          r_cap_z;
    logic          r_cap_n;
    logic          r_flag_z;
    logic          r_flag_n;
    logic          r_done;

    // The whole file clears on reset, so it is built from flops, not RAM
    logic [15:0]   r_rf [NREG];

    logic          w_idle;
    logic          w_accept;
    logic          w_load;
    logic          w_wb;
    logic [NREG-1:0] w_ld_sel;
    logic [NREG-1:0] w_wb_sel;

    assign w_idle   = (r_state == S_IDLE);
    assign w_accept = w_idle & bus.cmd_valid;
    // Loads are only honoured between commands
    assign w_load   = w_idle & bus.ld_en;
    assign w_wb     = (r_state == S_WB);

    // Per-entry write selects. Load and write-back never coincide,
    // because loads are only allowed in IDLE.
    genvar gi;
    generate
        for (gi = 0; gi < NREG; gi++) begin : g_sel
            assign w_ld_sel[gi] = w_load && (bus.ld_addr == AW'(gi));
            assign w_wb_sel[gi] = w_wb   && (r_dst       == AW'(gi));
        end
    endgenerate

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:  if (w_accept) r_state <= S_FETCH;
                S_FETCH: r_state <= S_EXEC;
                S_EXEC:  r_state <= S_WB;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Command latch. The fields only need to be stable at the handshake edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_opc  <= 3'd0;
            r_dst  <= '0;
            r_srca <= '0;
            r_srcb <= '0;
            r_cin  <= 1'b0;
        end else if (w_accept) begin
            r_opc  <= bus.cmd_opc;
            r_dst  <= bus.cmd_dst;
            r_srca <= bus.cmd_srca;
            r_srcb <= bus.cmd_srcb;
            r_cin  <= bus.cmd_cin;
        end
    end

    // ALU operand drive. It is loaded once in FETCH and then held,
    // so the ALU inputs stay stable through EXEC and also afterwards in IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_alu_a   <= 16'd0;
            r_alu_b   <= 16'd0;
            r_alu_c   <= 1'b0;
            r_alu_opc <= 3'd0;
        end else if (r_state == S_FETCH) begin
            r_alu_a   <= r_rf[r_srca];
            r_alu_b   <= r_rf[r_srcb];
            r_alu_c   <= r_cin;
            r_alu_opc <= r_opc;
        end
    end

    // Capture at the end of EXEC. The visible flags only move at write-back.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_result <= 16'd0;
            r_cap_z  <= 1'b0;
            r_cap_n  <= 1'b0;
            r_done   <= 1'b0;
            r_flag_z <= 1'b0;
            r_flag_n <= 1'b0;
        end else begin
            // done is high exactly for the WB cycle
            r_done <= (r_state == S_EXEC);
            if (r_state == S_EXEC) begin
                r_result <= bus.alu_w;
                r_cap_z  <= bus.alu_zer;
                r_cap_n  <= bus.alu_neg;
            end
            if (w_wb) begin
                r_flag_z <= r_cap_z;
                r_flag_n <= r_cap_n;
            end
        end
    end

    // Register file
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                r_rf[i] <= 16'd0;
            end
        end else begin
            for (int i = 0; i < NREG; i++) begin
                if (w_ld_sel[i]) begin
                    r_rf[i] <= bus.ld_data;
                end else if (w_wb_sel[i]) begin
                    r_rf[i] <= r_result;
                end
            end
        end
    end

    assign bus.cmd_ready = w_idle;
    assign bus.alu_a     = r_alu_a;
    assign bus.alu_b     = r_alu_b;
    assign bus.alu_c     = r_alu_c;
    assign bus.alu_opc   = r_alu_opc;
    assign bus.done      = r_done;
    assign bus.result    = r_result;
    assign bus.flag_z    = r_flag_z;
    assign bus.flag_n    = r_flag_n;
    assign bus.dbg_data  = r_rf[bus.dbg_addr];

endmodule

// File: tb/tb_alu_op_sequencer.sv
// ---------------------------------------------------------------------------
// tb_alu_op_sequencer
//   Directed bench for alu_op_sequencer. A combinational stand-in ALU sits on
//   the ALU side. A behavioural model tracks, per command, which clock edge
//   after acceptance makes each effect visible. A single compare process
//   checks all DUT outputs against that model on every falling edge.
//   Literal expectations pin the model to hand-computed values.
// ---------------------------------------------------------------------------
module tb_alu_op_sequencer;
    localparam int NREG = 4;
    localparam int AW   = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    alu_op_sequencer_if #(.NREG(NREG)) bus ();

    alu_op_sequencer #(.NREG(NREG)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Stand-in ALU: 000 -A, 001 A-B, 010 A+B+C, 011 (A-B)>>1, 100 AND, 101 OR, 110 XOR, 111 zero
    function automatic logic [15:0] alu_f(input logic [2:0] opc, input logic [15:0] a,
                                          input logic [15:0] b, input logic c);
        logic [15:0] d;
        d = a - b;
        case (opc)
            3'b000:  return 16'd0 - a;
            3'b001:  return d;
            3'b010:  return a + b + {15'd0, c};
            3'b011:  return d >> 1;
            3'b100:  return a & b;
            3'b101:  return a | b;
            3'b110:  return a ^ b;
            default: return 16'd0;
        endcase
    endfunction

    always_comb begin
        bus.alu_w   = alu_f(bus.alu_opc, bus.alu_a, bus.alu_b, bus.alu_c);
        bus.alu_zer = (bus.alu_w == 16'd0);
        bus.alu_neg = bus.alu_w[15];
    end

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [15:0]   m_rf [NREG];
    int            m_since;          // edges since acceptance, 0 = free
    logic [15:0]   m_a, m_b, m_result;
    logic          m_c, m_done, m_fz, m_fn;
    logic [2:0]    m_opc;
    logic [15:0]   p_a, p_b, p_res;
    logic          p_c;
    logic [2:0]    p_opc;
    logic [AW-1:0] p_dst;

    task automatic model_reset();
        for (int i = 0; i < NREG; i++) m_rf[i] = 16'd0;
        m_since = 0; m_a = 16'd0; m_b = 16'd0; m_c = 1'b0; m_opc = 3'd0;
        m_result = 16'd0; m_done = 1'b0; m_fz = 1'b0; m_fn = 1'b0;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk);
            if (rst) begin
                model_reset();
            end else if (m_since == 0) begin
                // Load first: a command accepted on this same edge sees the new value
                if (bus.ld_en) m_rf[bus.ld_addr] = bus.ld_data;
                if (bus.cmd_valid) begin
                    p_a   = m_rf[bus.cmd_srca];
                    p_b   = m_rf[bus.cmd_srcb];
                    p_c   = bus.cmd_cin;
                    p_opc = bus.cmd_opc;
                    p_dst = bus.cmd_dst;
                    p_res = alu_f(p_opc, p_a, p_b, p_c);
                    m_since = 1;
                end
            end else if (m_since == 1) begin
                m_a = p_a; m_b = p_b; m_c = p_c; m_opc = p_opc;
                m_since = 2;
            end else if (m_since == 2) begin
                m_result = p_res; m_done = 1'b1;
                m_since = 3;
            end else begin
                m_done = 1'b0;
                m_rf[p_dst] = p_res;
                m_fz = (p_res == 16'd0);
                m_fn = p_res[15];
                m_since = 0;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin
        forever begin
            @(negedge clk);
            chk1("cmd_ready", bus.cmd_ready, (m_since == 0));
            chk1("done",      bus.done,      m_done);
            chk ("result",    bus.result,    m_result);
            chk1("flag_z",    bus.flag_z,    m_fz);
            chk1("flag_n",    bus.flag_n,    m_fn);
            chk ("alu_a",     bus.alu_a,     m_a);
            chk ("alu_b",     bus.alu_b,     m_b);
            chk1("alu_c",     bus.alu_c,     m_c);
            chk ("alu_opc",   {13'd0, bus.alu_opc}, {13'd0, m_opc});
            chk ("dbg_data",  bus.dbg_data,  m_rf[bus.dbg_addr]);
        end
    end

    // ---------------- stimulus ----------------
    task automatic nxt();
        @(negedge clk);
        #1;
    endtask

    task automatic load(input logic [AW-1:0] addr, input logic [15:0] data);
        bus.ld_en = 1'b1; bus.ld_addr = addr; bus.ld_data = data;
        nxt();
        bus.ld_en = 1'b0;
    endtask

    task automatic issue(input logic [2:0] opc, input logic [AW-1:0] dst,
                         input logic [AW-1:0] a, input logic [AW-1:0] b, input logic cin);
        bus.cmd_valid = 1'b1; bus.cmd_opc = opc; bus.cmd_dst = dst;
        bus.cmd_srca = a; bus.cmd_srcb = b; bus.cmd_cin = cin;
    endtask

    // Runs one command, checks the done latency, and returns in the IDLE cycle after write-back
    task automatic run_cmd(input string nm, input logic [2:0] opc, input logic [AW-1:0] dst,
                           input logic [AW-1:0] a, input logic [AW-1:0] b, input logic cin);
        int lat;
        issue(opc, dst, a, b, cin);
        nxt();
        bus.cmd_valid = 1'b0;
        bus.ld_en = 1'b0;
        lat = 1;
        while (!bus.done && lat < 8) begin
            nxt();
            lat++;
        end
        chk({nm, "_done_latency"}, 16'(lat), 16'd3);
        nxt();
    endtask

    task automatic chk_reg(input string nm, input logic [AW-1:0] addr, input logic [15:0] exp);
        bus.dbg_addr = addr;
        #1;
        chk(nm, bus.dbg_data, exp);
    endtask

    task automatic chk_all_zero(input string nm);
        for (int i = 0; i < NREG; i++) chk_reg(nm, AW'(i), 16'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", n_tests);
        $fatal(1, "watchdog");
    end

    initial begin
        int hs [$];
        int k;
        bus.cmd_valid = 1'b0; bus.cmd_opc = 3'd0; bus.cmd_dst = '0;
        bus.cmd_srca = '0; bus.cmd_srcb = '0; bus.cmd_cin = 1'b0;
        bus.ld_en = 1'b0; bus.ld_addr = '0; bus.ld_data = 16'd0; bus.dbg_addr = '0;
        rst = 1'b1;
        nxt(); nxt();
        rst = 1'b0;
        nxt();

        // 1: reset state
        chk1("t1_ready", bus.cmd_ready, 1'b1);
        chk1("t1_done",  bus.done,      1'b0);
        chk1("t1_fz",    bus.flag_z,    1'b0);
        chk1("t1_fn",    bus.flag_n,    1'b0);
        chk_all_zero("t1_rf_zero");

        // 2: 5 + 3 + cin
        load(2'd0, 16'h0005);
        load(2'd1, 16'h0003);
        run_cmd("t2", 3'b010, 2'd2, 2'd0, 2'd1, 1'b1);
        chk ("t2_result", bus.result, 16'h0009);
        chk_reg("t2_r2", 2'd2, 16'h0009);
        chk1("t2_fz", bus.flag_z, 1'b0);
        chk1("t2_fn", bus.flag_n, 1'b0);

        // 3: negate R0
        run_cmd("t3", 3'b000, 2'd3, 2'd0, 2'd0, 1'b0);
        chk ("t3_result", bus.result, 16'hFFFB);
        chk_reg("t3_r3", 2'd3, 16'hFFFB);
        chk1("t3_fz", bus.flag_z, 1'b0);
        chk1("t3_fn", bus.flag_n, 1'b1);

        // 4: destination equals a source
        load(2'd0, 16'h0010);
        load(2'd1, 16'hFFF8);
        run_cmd("t4", 3'b011, 2'd0, 2'd0, 2'd1, 1'b0);
        chk ("t4_result", bus.result, 16'h000C);
        chk_reg("t4_r0", 2'd0, 16'h000C);

        // 4b: load and handshake on the same edge; the command sees the loaded value
        bus.ld_en = 1'b1; bus.ld_addr = 2'd1; bus.ld_data = 16'h0007;
        run_cmd("t4b", 3'b010, 2'd2, 2'd1, 2'd1, 1'b0);
        chk ("t4b_result", bus.result, 16'h000E);
        chk_reg("t4b_r1", 2'd1, 16'h0007);

        // 5: opcode 111 gives zero
        run_cmd("t5", 3'b111, 2'd1, 2'd0, 2'd1, 1'b0);
        chk ("t5_result", bus.result, 16'h0000);
        chk1("t5_fz", bus.flag_z, 1'b1);
        chk1("t5_fn", bus.flag_n, 1'b0);
        chk_reg("t5_r1", 2'd1, 16'h0000);

        // 5b: valid held high for two commands; loads while busy must be ignored
        issue(3'b010, 2'd3, 2'd2, 2'd2, 1'b1);
        k = 0;
        while (hs.size() < 2 && k < 12) begin
            if (bus.cmd_ready) hs.push_back(k);
            bus.ld_en   = (k >= 1 && k <= 3);
            bus.ld_addr = 2'd3;
            bus.ld_data = 16'hDEAD;
            nxt();
            k++;
        end
        bus.cmd_valid = 1'b0;
        bus.ld_en = 1'b0;
        if (hs.size() == 2) begin
            chk("t5_hs_spacing", 16'(hs[1] - hs[0]), 16'd4);
        end else begin
            chk("t5_hs_count", 16'(hs.size()), 16'd2);
        end
        k = 0;
        while (!bus.done && k < 8) begin
            nxt();
            k++;
        end
        chk1("t5b_done_seen", bus.done, 1'b1);
        chk ("t5b_result", bus.result, 16'h001D);
        nxt();
        chk_reg("t5b_r3", 2'd3, 16'h001D);

        // 6: reset during EXEC
        load(2'd0, 16'h1234);
        issue(3'b010, 2'd1, 2'd0, 2'd0, 1'b0);
        nxt();
        bus.cmd_valid = 1'b0;
        nxt();
        rst = 1'b1;
        #1;
        chk1("t6_ready_in_rst", bus.cmd_ready, 1'b1);
        chk1("t6_done_in_rst",  bus.done,      1'b0);
        chk ("t6_result_rst",   bus.result,    16'h0000);
        chk_all_zero("t6_rf_zero");
        nxt(); nxt();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            nxt();
            chk1("t6_no_done", bus.done, 1'b0);
        end
        chk1("t6_ready_after", bus.cmd_ready, 1'b1);
        chk_all_zero("t6_rf_still_zero");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
